// File: rtl/stream_rr_arbiter.sv
// Round-robin merge of NUM_REQ valid/ready packet streams into one registered stream.
// Packets are never interleaved; the output is tagged with the source index.
module stream_rr_arbiter #(
    parameter int unsigned  NUM_REQ    = 4,
    parameter int unsigned  DATA_WIDTH = 32,
    localparam int unsigned SRC_WIDTH  = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [SRC_WIDTH-1:0]          out_src,
    output logic                          out_last,
    output logic                          out_valid,
    input  logic                          out_ready
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    localparam logic [SRC_WIDTH-1:0] LAST_IDX = SRC_WIDTH'(NUM_REQ - 1);

    logic [0:0]            state;
    logic [0:0]            state_nxt;
    logic [SRC_WIDTH-1:0]  owner;
    logic [SRC_WIDTH-1:0]  owner_nxt;
    logic [SRC_WIDTH-1:0]  rr_ptr;
    logic [SRC_WIDTH-1:0]  rr_ptr_nxt;
    logic [DATA_WIDTH-1:0] out_data_nxt;
    logic [SRC_WIDTH-1:0]  out_src_nxt;
    logic                  out_last_nxt;
    logic                  out_valid_nxt;

    logic                  load_en;
    logic                  rr_hit;
    logic [SRC_WIDTH-1:0]  rr_grant;
    logic                  grant_vld;
    logic [SRC_WIDTH-1:0]  grant;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_last;
    logic                  xfer;

    assign load_en = !out_valid || out_ready;

    // Rotating priority: the lowest valid index overall is the wrap-around fallback,
    // overridden by the lowest valid index at or above rr_ptr.
    always_comb begin
        rr_hit   = 1'b0;
        rr_grant = '0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                rr_hit   = 1'b1;
                rr_grant = SRC_WIDTH'(i);
            end
        end
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (req_valid[i] && (SRC_WIDTH'(i) >= rr_ptr)) begin
                rr_grant = SRC_WIDTH'(i);
            end
        end
    end

    assign grant     = (state == LOCKED) ? owner : rr_grant;
    assign grant_vld = (state == LOCKED) || rr_hit;

    // Per-requester ready and payload select, one-hot on grant.
    always_comb begin
        req_ready = '0;
        sel_data  = '0;
        sel_last  = 1'b0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (grant == SRC_WIDTH'(i)) begin
                req_ready[i] = grant_vld && load_en && rst;
                sel_data     = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                sel_last     = req_last[i];
            end
        end
    end

    assign xfer = |(req_valid & req_ready);

    // Next-state: lock on a non-last beat, release and rotate on the last beat.
    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
        rr_ptr_nxt    = rr_ptr;
        out_data_nxt  = out_data;
        out_src_nxt   = out_src;
        out_last_nxt  = out_last;
        out_valid_nxt = out_valid;

        if (xfer) begin
            out_data_nxt  = sel_data;
            out_src_nxt   = grant;
            out_last_nxt  = sel_last;
            out_valid_nxt = 1'b1;
            if (sel_last) begin
                state_nxt  = IDLE;
                rr_ptr_nxt = (grant == LAST_IDX) ? '0 : grant + SRC_WIDTH'(1);
            end else begin
                state_nxt = LOCKED;
                owner_nxt = grant;
            end
        end else if (out_ready) begin
            out_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            out_data  <= '0;
            out_src   <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            rr_ptr    <= rr_ptr_nxt;
            out_data  <= out_data_nxt;
            out_src   <= out_src_nxt;
            out_last  <= out_last_nxt;
            out_valid <= out_valid_nxt;
        end
    end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed bench for stream_rr_arbiter: a 4-requester and a 3-requester instance.
module tb_stream_rr_arbiter;

    logic         clk;
    logic         rst;

    logic [127:0] req_data;
    logic [3:0]   req_last;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [31:0]  out_data;
    logic [1:0]   out_src;
    logic         out_last;
    logic         out_valid;
    logic         out_ready;

    logic [23:0]  r3_data;
    logic [2:0]   r3_last;
    logic [2:0]   r3_valid;
    logic [2:0]   r3_ready;
    logic [7:0]   o3_data;
    logic [1:0]   o3_src;
    logic         o3_last;
    logic         o3_valid;
    logic         o3_ready;

    int checks = 0;
    int errors = 0;

    stream_rr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32)) dut4 (
        .clk(clk), .rst(rst),
        .req_data(req_data), .req_last(req_last), .req_valid(req_valid), .req_ready(req_ready),
        .out_data(out_data), .out_src(out_src), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    stream_rr_arbiter #(.NUM_REQ(3), .DATA_WIDTH(8)) dut3 (
        .clk(clk), .rst(rst),
        .req_data(r3_data), .req_last(r3_last), .req_valid(r3_valid), .req_ready(r3_ready),
        .out_data(o3_data), .out_src(o3_src), .out_last(o3_last),
        .out_valid(o3_valid), .out_ready(o3_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input int i, input logic [31:0] val);
        req_data[i*32 +: 32] = val;
    endtask

    initial begin
        logic [1:0] seq4 [6];
        logic [1:0] seq3 [4];
        seq4 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        seq3 = '{2'd2, 2'd0, 2'd1, 2'd2};

        rst       = 1'b0;
        req_data  = '0;
        req_last  = '0;
        req_valid = '0;
        out_ready = 1'b1;
        r3_data   = {8'h52, 8'h51, 8'h50};
        r3_last   = 3'b111;
        r3_valid  = '0;
        o3_ready  = 1'b1;

        // Reset state, with requests already pending
        for (int i = 0; i < 4; i++) set_word(i, 32'h1000 + 32'(i));
        req_last  = 4'b1111;
        req_valid = 4'b1111;
        tick();
        tick();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_src", 64'(out_src), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);

        // All four requesters with 1-beat packets, back to back
        rst = 1'b1;
        #1;
        check("t1_ready_first", 64'(req_ready), 64'b0001);
        for (int s = 0; s < 6; s++) begin
            tick();
            check("t1_valid", 64'(out_valid), 64'd1);
            check("t1_src", 64'(out_src), 64'(seq4[s]));
            check("t1_data", 64'(out_data), 64'(32'h1000 + 32'(seq4[s])));
            check("t1_last", 64'(out_last), 64'd1);
        end
        req_valid = '0;
        tick();
        check("t1_drain", 64'(out_valid), 64'd0);

        // Requester 2 three-beat packet while requester 0 waits (rr_ptr=2)
        set_word(0, 32'h200);
        req_last  = 4'b0001;
        set_word(2, 32'hA);
        req_valid = 4'b0101;
        #1;
        check("t2_ready_a", 64'(req_ready), 64'b0100);
        tick();
        check("t2_a_data", 64'(out_data), 64'hA);
        check("t2_a_src", 64'(out_src), 64'd2);
        check("t2_a_last", 64'(out_last), 64'd0);
        set_word(2, 32'hB);
        #1;
        check("t2_ready_b", 64'(req_ready), 64'b0100);
        tick();
        check("t2_b_data", 64'(out_data), 64'hB);
        check("t2_b_src", 64'(out_src), 64'd2);
        check("t2_b_last", 64'(out_last), 64'd0);
        set_word(2, 32'hC);
        req_last = 4'b0101;
        #1;
        check("t2_ready_c", 64'(req_ready), 64'b0100);
        tick();
        check("t2_c_data", 64'(out_data), 64'hC);
        check("t2_c_src", 64'(out_src), 64'd2);
        check("t2_c_last", 64'(out_last), 64'd1);
        req_valid = 4'b0001;
        #1;
        check("t2_ready_r0", 64'(req_ready), 64'b0001);
        tick();
        check("t2_r0_data", 64'(out_data), 64'h200);
        check("t2_r0_src", 64'(out_src), 64'd0);
        req_valid = '0;
        tick();
        check("t2_drain", 64'(out_valid), 64'd0);

        // Requester 1 stalls mid-packet while requester 3 waits (rr_ptr=1)
        set_word(1, 32'h31);
        set_word(3, 32'h33);
        req_last  = 4'b1000;
        req_valid = 4'b1010;
        tick();
        check("t3_x_src", 64'(out_src), 64'd1);
        check("t3_x_data", 64'(out_data), 64'h31);
        check("t3_x_last", 64'(out_last), 64'd0);
        req_valid = 4'b1000;
        #1;
        check("t3_stall_ready", 64'(req_ready), 64'b0010);
        tick();
        check("t3_stall1_valid", 64'(out_valid), 64'd0);
        tick();
        check("t3_stall2_valid", 64'(out_valid), 64'd0);
        check("t3_stall2_ready", 64'(req_ready), 64'b0010);
        set_word(1, 32'h32);
        req_last  = 4'b1010;
        req_valid = 4'b1010;
        tick();
        check("t3_y_src", 64'(out_src), 64'd1);
        check("t3_y_data", 64'(out_data), 64'h32);
        check("t3_y_last", 64'(out_last), 64'd1);
        req_valid = 4'b1000;
        tick();
        check("t3_r3_src", 64'(out_src), 64'd3);
        check("t3_r3_data", 64'(out_data), 64'h33);
        req_valid = '0;
        tick();
        check("t3_drain", 64'(out_valid), 64'd0);

        // Backpressure for three cycles, then drain and reload on one edge (rr_ptr=0)
        set_word(0, 32'h40);
        set_word(1, 32'h41);
        req_last  = 4'b1111;
        req_valid = 4'b0001;
        tick();
        check("t4_p_data", 64'(out_data), 64'h40);
        req_valid = 4'b0011;
        out_ready = 1'b0;
        #1;
        check("t4_bp_ready0", 64'(req_ready), 64'b0000);
        for (int s = 0; s < 3; s++) begin
            tick();
            check("t4_hold_valid", 64'(out_valid), 64'd1);
            check("t4_hold_data", 64'(out_data), 64'h40);
            check("t4_hold_src", 64'(out_src), 64'd0);
            check("t4_hold_ready", 64'(req_ready), 64'b0000);
        end
        out_ready = 1'b1;
        #1;
        check("t4_release_ready", 64'(req_ready), 64'b0010);
        tick();
        check("t4_q_valid", 64'(out_valid), 64'd1);
        check("t4_q_data", 64'(out_data), 64'h41);
        check("t4_q_src", 64'(out_src), 64'd1);
        req_valid = '0;
        tick();
        check("t4_drain", 64'(out_valid), 64'd0);

        // Three requesters: wrap from index 2 back to 0
        r3_valid = 3'b010;
        tick();
        check("t5_pre_src", 64'(o3_src), 64'd1);
        r3_valid = 3'b111;
        #1;
        check("t5_ready", 64'(r3_ready), 64'b100);
        for (int s = 0; s < 4; s++) begin
            tick();
            check("t5_valid", 64'(o3_valid), 64'd1);
            check("t5_src", 64'(o3_src), 64'(seq3[s]));
            check("t5_data", 64'(o3_data), 64'(8'h50 + 8'(seq3[s])));
        end
        r3_valid = '0;

        // Reset while locked to requester 3 (dut4 rr_ptr=2)
        set_word(3, 32'h60);
        req_last  = 4'b0000;
        req_valid = 4'b1000;
        tick();
        check("t6_r_src", 64'(out_src), 64'd3);
        check("t6_r_last", 64'(out_last), 64'd0);
        rst = 1'b0;
        #1;
        check("t6_rst_valid", 64'(out_valid), 64'd0);
        check("t6_rst_ready", 64'(req_ready), 64'b0000);
        tick();
        rst = 1'b1;
        set_word(0, 32'h70);
        req_last  = 4'b0001;
        req_valid = 4'b1001;
        #1;
        check("t6_post_ready", 64'(req_ready), 64'b0001);
        tick();
        check("t6_post_src", 64'(out_src), 64'd0);
        check("t6_post_data", 64'(out_data), 64'h70);
        check("t6_post_valid", 64'(out_valid), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
